// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_rx
//  Description : 8N1 UART byte receiver, LSB first. The raw rx pin passes
//                through a SYNC_STAGES-deep synchroniser. Each start bit is
//                validated at its centre, and every data and stop bit is
//                sampled at its centre. A good byte is presented on
//                o_rx_data together with a one-cycle o_rx_en strobe. A byte
//                whose stop bit reads 0 is dropped and reported by a
//                one-cycle o_frame_err strobe.
//
//  Ports       : i_clk        clock
//                i_rst        asynchronous reset, active-high
//                i_uart_rx    raw UART line (idle level 1)
//                o_rx_data    last good byte, held until the next good byte
//                o_rx_en      one-cycle strobe, o_rx_data is new this cycle
//                o_frame_err  one-cycle strobe, stop bit was 0, byte dropped
//                o_busy       high while a frame is being received
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_rx #(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_en,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int c_CLKS_PER_BIT = (CLOCK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (c_CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("uart_byte_rx: SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [SYNC_STAGES-1:0]   r_sync;
    logic [SYNC_STAGES-1:0]   r_primed;
    logic                     w_rx_s;
    logic                     w_primed;

    logic [c_CNT_W-1:0]       r_cnt;
    logic [c_CNT_W-1:0]       w_cnt_next;
    logic [2:0]               r_bit_idx;
    logic [2:0]               w_bit_idx_next;
    logic [7:0]               r_shift;
    logic [7:0]               w_shift_next;

    logic [7:0]               r_rx_data;
    logic [7:0]               w_rx_data_next;
    logic                     r_rx_en;
    logic                     w_rx_en_next;
    logic                     r_frame_err;
    logic                     w_frame_err_next;
    logic                     r_busy;
    logic                     w_busy_next;

    // ------------------------------------------------------------------
    // rx synchroniser. r_primed tracks how many stages have been loaded
    // from the real pin since reset: the reset value of the synchroniser
    // is 1 and must not be mistaken for an idle line, otherwise a frame
    // that was cut by reset could be picked up from its middle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= '1;
            r_primed <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_uart_rx};
            r_primed <= {r_primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rx_s   = r_sync[SYNC_STAGES-1];
    assign w_primed = r_primed[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt + 1'b1;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_en_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            ST_WAIT_IDLE: begin
                w_cnt_next = '0;
                if (w_primed && w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_IDLE: begin
                w_cnt_next     = '0;
                w_bit_idx_next = 3'd0;
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                // A start bit that is gone by its centre was a glitch.
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                // Counter restarts per bit so each sample lands a full
                // bit period after the previous centre.
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                // Leaving at mid-stop-bit lets a start edge that follows
                // the stop bit directly be caught.
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_rx_data_next = r_shift;
                        w_rx_en_next   = 1'b1;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = ST_WAIT_IDLE;
                    end
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_WAIT_IDLE;
            end
        endcase

        w_busy_next = (w_state_next == ST_START) ||
                      (w_state_next == ST_DATA)  ||
                      (w_state_next == ST_STOP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_en     <= w_rx_en_next;
            r_frame_err <= w_frame_err_next;
            r_busy      <= w_busy_next;
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_en     = r_rx_en;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_rx
//  Description : Self-checking bench for uart_byte_rx. Frames are driven
//                bit-serially on the line; every strobe is compared against
//                an expected-event queue filled from a frame-level model
//                (good stop -> byte, bad stop -> frame error holding the
//                last good byte).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_byte_rx;

    localparam int c_CPB    = 9;   // (1_000_000 + 57_600) / 115_200
    localparam int c_HALF   = 4;
    localparam int c_PERIOD = 10;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] last_good;
    logic       prev_strobe;
    int         en_count;
    time        t_start;
    time        t_en;

    uart_byte_rx #(
        .CLOCK_FREQUENCY(1_000_000),
        .BAUD_RATE      (115_200),
        .SYNC_STAGES    (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_uart_rx  (rx),
        .o_rx_data  (rx_data),
        .o_rx_en    (rx_en),
        .o_frame_err(frame_err),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #(c_PERIOD / 2) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: sampled on the falling edge, away from the active edge.
    initial begin
        prev_strobe = 1'b0;
        en_count    = 0;
        t_en        = 0;
    end

    always @(negedge clk) begin
        if (rx_en || frame_err) begin
            chk("no_overlap", 32'(rx_en & frame_err), 32'd0);
            chk("no_back_to_back", 32'(prev_strobe), 32'd0);
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind_is_err", 32'(frame_err), 32'(e.err));
                chk("strobe_data", 32'(rx_data), 32'(e.data));
            end
            chk("busy_low_at_strobe", 32'(busy), 32'd0);
            if (rx_en) begin
                en_count++;
                t_en = $time;
            end
        end
        prev_strobe = rx_en | frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame, LSB first; called at a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        t_start = $time;
        rx = 1'b0;
        wait_clks(c_CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(c_CPB);
        end
        rx = stop;
        wait_clks(c_CPB);
        if (gap > 0) begin
            rx = 1'b1;
            wait_clks(gap * c_CPB);
        end
    endtask

    // Frame-level reference: what the receiver must report for a frame.
    task automatic model_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        if (stop) begin
            e.err     = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.err  = 1'b1;
            e.data = last_good;
        end
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        int lat;
        int busy_cnt;
        int en_before;

        // Expected results are written by hand from the frame contents.
        vecs[0] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
        vecs[2] = '{8'h55, 1'b1, 1, 1'b0, 8'h55};
        vecs[3] = '{8'h01, 1'b1, 1, 1'b0, 8'h01};
        vecs[4] = '{8'h80, 1'b1, 1, 1'b0, 8'h80};
        vecs[5] = '{8'hC3, 1'b0, 2, 1'b1, 8'h80};

        rst       = 1'b1;
        rx        = 1'b1;
        last_good = 8'h00;
        wait_clks(5);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_en", 32'(rx_en), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clks(2 * c_CPB);

        // Single frame with latency check.
        en_before = en_count;
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, 2);
        drain("drain_a5", 40);
        chk("a5_single_pulse", 32'(en_count - en_before), 32'd1);
        lat = int'((t_en - t_start) / c_PERIOD);
        chk("a5_latency_88pm1", 32'(lat >= 87 && lat <= 89), 32'd1);

        // Table: back-to-back frames, bit order, a bad stop bit.
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.err  = vecs[i].exp_err;
            e.data = vecs[i].exp_data;
            exp_q.push_back(e);
            if (vecs[i].stop) last_good = vecs[i].data;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap);
        end
        drain("drain_table", 40);

        // Glitch shorter than half a bit.
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 3 * c_CPB; i++) begin
            if (i == 3) rx = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("glitch_busy_1_to_half", 32'(busy_cnt >= 1 && busy_cnt <= c_HALF), 32'd1);

        // Bad stop bit followed by a long break, then a good frame.
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, 0);
        wait_clks(20 * c_CPB);
        chk("break_busy_low", 32'(busy), 32'd0);
        rx = 1'b1;
        wait_clks(c_CPB);
        model_frame(8'h7E, 1'b1);
        send_frame(8'h7E, 1'b1, 1);
        drain("drain_break", 40);

        // Reset during bit 4 of 0x0F, released while the line is still low.
        rx = 1'b0;
        wait_clks(c_CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clks(c_CPB);
        end
        rx = 1'b0;
        wait_clks(2);
        rst = 1'b1;
        last_good = 8'h00;
        wait_clks(3);
        chk("midframe_reset_data", 32'(rx_data), 32'h00);
        chk("midframe_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clks(c_CPB - 5 + 3 * c_CPB);
        rx = 1'b1;
        wait_clks(3 * c_CPB);
        chk("cut_frame_no_strobe", 32'(exp_q.size()), 32'd0);
        model_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1, 1);
        drain("drain_reset", 40);

        // Randomised frames against the frame-level model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            model_frame(d, stop);
            send_frame(d, stop, gap);
        end
        drain("drain_random", 40);
        chk("final_rx_data", 32'(rx_data), 32'(last_good));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
